div8_seq: RTL and testbench

DIV8_SEQ -- requirements
Module: div8_seq

---
 rtl/div8_seq.sv | 83 ++++++++
 tb/tb_div8_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div8_seq.sv
// div8_seq: sequential 8-bit unsigned restoring divider, one quotient bit per cycle.
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   dividend     unsigned dividend, captured on accepted start
//   divisor      unsigned divisor, captured on accepted start
//   quotient     registered quotient (8'hFF on divide-by-zero)
//   remainder    registered remainder (dividend on divide-by-zero)
//   busy         high during the 8 CALC cycles
//   done         one-cycle result-valid pulse
//   div_by_zero  registered flag, loaded together with the result
module div8_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] a, d;
    logic [6:0] q;
    logic [8:0] rem, shifted, rem_nx;
    logic [9:0] sum;
    logic [2:0] cnt;
    logic       qbit, accept;
    assign accept = state == IDLE && start;
    assign busy   = state == CALC;
    assign done   = state == DONE;
    // rem[8] is always 0 after a step, so prepending it keeps the 10-bit add exact.
    always_comb begin
        shifted = {rem[7:0], a[3'd7 - cnt]};
        sum     = {rem[8], shifted} + {1'b0, ~{1'b0, d}} + 10'd1;
        qbit    = sum[9];
        rem_nx  = qbit ? sum[8:0] : shifted;
    end
    always_comb begin
        state_nx = state == IDLE ? (start ? (divisor == 8'd0 ? DONE : CALC) : IDLE)
                 : state == CALC ? (cnt == 3'd7 ? DONE : CALC)
                 : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            d           <= '0;
            q           <= '0;
            rem         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            a   <= dividend;
            d   <= divisor;
            q   <= '0;
            rem <= '0;
            cnt <= '0;
            if (divisor == 8'd0) begin
                quotient    <= 8'hFF;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            rem <= rem_nx;
            cnt <= cnt + 3'd1;
            q   <= {q[5:0], qbit};
            if (cnt == 3'd7) begin
                quotient    <= {q, qbit};
                remainder   <= rem_nx[7:0];
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div8_seq.sv
// tb_div8_seq: scoreboard bench for div8_seq against an arithmetic reference model.
module tb_div8_seq;
    logic       clk = 0, rst_n = 1, start = 0;
    logic [7:0] dividend = 0, divisor = 0;
    logic [7:0] quotient, remainder;
    logic       busy, done, div_by_zero;
    int         checks = 0, failures = 0, dones = 0, accepted = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;

    div8_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [7:0] x, input logic [7:0] y);
        if (y == 8'd0) return {1'b1, 8'hFF, x};
        return {1'b0, 8'(x / y), 8'(x % y)};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_overlap", busy & done, 0);
            if (done) begin
                dones++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: done=1 with no pending result");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("quotient", quotient, mon_e[15:8]);
                    check("remainder", remainder, mon_e[7:0]);
                    check("div_by_zero", div_by_zero, mon_e[16]);
                end
            end
        end
    end

    task automatic run(input logic [7:0] x, input logic [7:0] y, input bit glitch);
        int busy_n = 0, done_k = 0;
        logic [16:0] prev;
        @(negedge clk);
        prev = {quotient, remainder, div_by_zero};
        dividend = x;
        divisor = y;
        start = 1;
        exp_q.push_back(model(x, y));
        accepted++;
        @(negedge clk);
        start = 0;
        dividend = 8'($urandom);
        divisor = 8'($urandom);
        for (int k = 1; k <= 20; k++) begin
            if (busy) begin
                busy_n++;
                check("hold_outputs", {quotient, remainder, div_by_zero}, prev);
            end
            if (glitch && k == 4) begin
                start = 1;
                dividend = 10;
                divisor = 3;
            end
            if (glitch && k == 5) start = 0;
            if (done) begin
                done_k = k;
                break;
            end
            @(negedge clk);
        end
        check("busy_cycles", busy_n, y != 0 ? 8 : 0);
        check("done_latency", done_k, y != 0 ? 9 : 1);
    endtask

    initial begin
        int t1, t2, nd;
        #1 rst_n = 0;
        #2;
        check("reset_outputs", {quotient, remainder, busy, done, div_by_zero}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        run(200, 7, 0);
        run(255, 1, 0);
        run(5, 10, 0);
        run(0, 3, 0);
        run(255, 255, 0);
        run(77, 0, 0);
        run(9, 2, 0);
        run(200, 7, 1);
        // start held high: back-to-back runs separated by one idle cycle
        @(negedge clk);
        dividend = 50;
        divisor = 6;
        start = 1;
        exp_q.push_back(model(50, 6));
        exp_q.push_back(model(50, 6));
        accepted += 2;
        t1 = 0;
        t2 = 0;
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) t1 = k;
                else begin
                    t2 = k;
                    break;
                end
            end
        end
        start = 0;
        check("rerun_period", t2 - t1, 10);
        // reset in CALC cycle 5 aborts the run
        @(negedge clk);
        dividend = 200;
        divisor = 7;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        check("busy_before_reset", busy, 1);
        rst_n = 0;
        #1;
        check("reset_mid_calc", {quotient, remainder, busy, done, div_by_zero}, 0);
        repeat (2) @(negedge clk);
        check("no_done_in_reset", done, 0);
        rst_n = 1;
        run(100, 9, 0);
        for (int i = 0; i < 256; i++) run(8'd255, 8'(i), 0);
        for (int i = 0; i < 256; i++) run(8'(i), 8'(i % 17), 0);
        for (int i = 0; i < 2000; i++)
            run(8'($urandom), ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom), 0);
        repeat (3) @(negedge clk);
        check("done_count", dones, accepted);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
